// File: rtl/serial_display_driver.sv
// Driver for a chain of serial-in/parallel-out display shift registers.
// Each frame shifts NBITS bits on sclk/sdata, latches them with sload, then idles until the next refresh.

module serial_display_driver_checker (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic sdata,
    input  logic sload,
    input  logic frame_done,
    input  logic sclr_n
);

    // The chain must never see shifting while it is loading.
    a_load_quiet : assert property (@(posedge clk) disable iff (!rst_n)
        sload |-> (!sclk && !sdata));

    // frame_done only marks a cycle in which sload is high.
    a_done_in_load : assert property (@(posedge clk) disable iff (!rst_n)
        frame_done |-> sload);

    // Once the chain clear is released it stays released until the next reset.
    a_clear_sticky : assert property (@(posedge clk) disable iff (!rst_n)
        sclr_n |=> sclr_n);

endmodule

module serial_display_driver #(
    parameter int unsigned NBITS          = 72,
    parameter int unsigned SCLK_HALF      = 16,
    parameter int unsigned LOAD_CYCLES    = 4096,
    parameter int unsigned REFRESH_CYCLES = 131072,
    parameter bit          MSB_FIRST      = 1'b0,
    parameter bit          EARLY_UPDATE   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBITS-1:0] display_bits,
    input  logic             update_valid,
    output logic             update_ready,
    output logic             frame_done,
    output logic             sclk,
    output logic             sdata,
    output logic             sload,
    output logic             sclr_n
);

    localparam int unsigned SLOT_CYCLES = 2 * SCLK_HALF;
    localparam int unsigned FC_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned PH_W   = $clog2(SLOT_CYCLES);
    localparam int unsigned SLOT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int unsigned LD_W   = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(REFRESH_CYCLES - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SLOT_CYCLES - 1);
    localparam logic [PH_W-1:0]   PH_RISE   = PH_W'(SCLK_HALF);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NBITS - 1);
    localparam logic [LD_W-1:0]   LD_LAST   = LD_W'(LOAD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SHIFT = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            state_r, state_next_s;
    logic [FC_W-1:0]   fc_r, fc_next_s;
    logic [PH_W-1:0]   ph_r, ph_next_s;
    logic [SLOT_W-1:0] slot_r, slot_next_s;
    logic [LD_W-1:0]   ld_r, ld_next_s;

    logic [NBITS-1:0]  active_r, active_next_s;
    logic [NBITS-1:0]  pending_r, pending_next_s;
    logic              pending_full_r, pending_full_next_s;

    logic              sclk_r, sdata_r, sload_r, frame_done_r, sclr_n_r, update_ready_r;
    logic              sclk_next_s, sdata_next_s, sload_next_s, frame_done_next_s;

    logic              accept_s;
    logic              go_shift_s;

    // Selects the frame bit carried by a given slot, honouring shift order.
    function automatic logic slot_bit(input logic [NBITS-1:0] frame, input logic [SLOT_W-1:0] slot);
        logic [SLOT_W-1:0] idx;
        if (MSB_FIRST) begin
            idx = SLOT_LAST - slot;
        end else begin
            idx = slot;
        end
        return frame[idx];
    endfunction

    assign accept_s   = update_valid & update_ready_r;
    assign go_shift_s = (state_r == ST_WAIT) &&
                        ((fc_r == FC_LAST) || (EARLY_UPDATE && accept_s));

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_SHIFT;
            fc_r    <= '0;
            ph_r    <= '0;
            slot_r  <= '0;
            ld_r    <= '0;
        end else begin
            state_r <= state_next_s;
            fc_r    <= fc_next_s;
            ph_r    <= ph_next_s;
            slot_r  <= slot_next_s;
            ld_r    <= ld_next_s;
        end
    end

    // Next-state and counter sequencing through SHIFT -> LOAD -> WAIT.
    always_comb begin
        state_next_s = state_r;
        fc_next_s    = fc_r + FC_W'(1);
        ph_next_s    = ph_r;
        slot_next_s  = slot_r;
        ld_next_s    = ld_r;
        case (state_r)
            ST_SHIFT: begin
                if (ph_r == PH_LAST) begin
                    ph_next_s = '0;
                    if (slot_r == SLOT_LAST) begin
                        slot_next_s  = '0;
                        ld_next_s    = '0;
                        state_next_s = ST_LOAD;
                    end else begin
                        slot_next_s = slot_r + SLOT_W'(1);
                    end
                end else begin
                    ph_next_s = ph_r + PH_W'(1);
                end
            end
            ST_LOAD: begin
                if (ld_r == LD_LAST) begin
                    ld_next_s    = '0;
                    state_next_s = ST_WAIT;
                end else begin
                    ld_next_s = ld_r + LD_W'(1);
                end
            end
            ST_WAIT: begin
                if (go_shift_s) begin
                    state_next_s = ST_SHIFT;
                    fc_next_s    = '0;
                    ph_next_s    = '0;
                    slot_next_s  = '0;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: begin
                // Unreachable encoding: restart a clean frame.
                state_next_s = ST_SHIFT;
                fc_next_s    = '0;
                ph_next_s    = '0;
                slot_next_s  = '0;
                ld_next_s    = '0;
            end
        endcase
    end

    // Double-buffer update: a frame only changes at SHIFT entry.
    always_comb begin
        active_next_s       = active_r;
        pending_next_s      = pending_r;
        pending_full_next_s = pending_full_r;
        if (go_shift_s) begin
            if (accept_s) begin
                active_next_s = display_bits;
            end else if (pending_full_r) begin
                active_next_s = pending_r;
            end else begin
                active_next_s = active_r;
            end
            pending_full_next_s = 1'b0;
        end else if (accept_s) begin
            pending_next_s      = display_bits;
            pending_full_next_s = 1'b1;
        end else begin
            pending_full_next_s = pending_full_r;
        end
    end

    // Frame buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r       <= '0;
            pending_r      <= '0;
            pending_full_r <= 1'b0;
        end else begin
            active_r       <= active_next_s;
            pending_r      <= pending_next_s;
            pending_full_r <= pending_full_next_s;
        end
    end

    // Output decode from the upcoming state so registered pins line up with it.
    always_comb begin
        sclk_next_s       = 1'b0;
        sdata_next_s      = 1'b0;
        sload_next_s      = 1'b0;
        frame_done_next_s = 1'b0;
        case (state_next_s)
            ST_SHIFT: begin
                sclk_next_s  = (ph_next_s >= PH_RISE);
                sdata_next_s = slot_bit(active_next_s, slot_next_s);
            end
            ST_LOAD: begin
                sload_next_s      = 1'b1;
                frame_done_next_s = (ld_next_s == LD_LAST);
            end
            ST_WAIT: begin
                sload_next_s = 1'b0;
            end
            default: begin
                sload_next_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_r         <= 1'b0;
            sdata_r        <= 1'b0;
            sload_r        <= 1'b0;
            frame_done_r   <= 1'b0;
            sclr_n_r       <= 1'b0;
            update_ready_r <= 1'b0;
        end else begin
            sclk_r         <= sclk_next_s;
            sdata_r        <= sdata_next_s;
            sload_r        <= sload_next_s;
            frame_done_r   <= frame_done_next_s;
            sclr_n_r       <= 1'b1;
            update_ready_r <= ~pending_full_next_s;
        end
    end

    assign sclk         = sclk_r;
    assign sdata        = sdata_r;
    assign sload        = sload_r;
    assign frame_done   = frame_done_r;
    assign sclr_n       = sclr_n_r;
    assign update_ready = update_ready_r;

    serial_display_driver_checker u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk_r),
        .sdata      (sdata_r),
        .sload      (sload_r),
        .frame_done (frame_done_r),
        .sclr_n     (sclr_n_r)
    );

endmodule

// File: tb/tb_serial_display_driver.sv
// Directed bench: three driver instances (plain, early-update, MSB-first) exercised one at a time
// while the others are held in reset; outputs are compared cycle by cycle against hand-derived frames.

module tb_serial_display_driver;

    logic       clk;
    logic       rst0, rst_e, rst_m;
    logic [7:0] display_bits;
    logic       update_valid;
    logic [2:0] rdy, fd, sclk, sdata, sload, sclr_n;
    logic [1:0] sel;
    int         n_checks, n_errors;

    serial_display_driver #(.NBITS(8), .SCLK_HALF(2), .LOAD_CYCLES(4), .REFRESH_CYCLES(64),
                            .MSB_FIRST(1'b0), .EARLY_UPDATE(1'b0)) dut (
        .clk(clk), .rst_n(rst0), .display_bits(display_bits), .update_valid(update_valid),
        .update_ready(rdy[0]), .frame_done(fd[0]), .sclk(sclk[0]), .sdata(sdata[0]),
        .sload(sload[0]), .sclr_n(sclr_n[0]));

    serial_display_driver #(.NBITS(8), .SCLK_HALF(2), .LOAD_CYCLES(4), .REFRESH_CYCLES(64),
                            .MSB_FIRST(1'b0), .EARLY_UPDATE(1'b1)) dut_e (
        .clk(clk), .rst_n(rst_e), .display_bits(display_bits), .update_valid(update_valid),
        .update_ready(rdy[1]), .frame_done(fd[1]), .sclk(sclk[1]), .sdata(sdata[1]),
        .sload(sload[1]), .sclr_n(sclr_n[1]));

    serial_display_driver #(.NBITS(8), .SCLK_HALF(2), .LOAD_CYCLES(4), .REFRESH_CYCLES(64),
                            .MSB_FIRST(1'b1), .EARLY_UPDATE(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_m), .display_bits(display_bits), .update_valid(update_valid),
        .update_ready(rdy[2]), .frame_done(fd[2]), .sclk(sclk[2]), .sdata(sdata[2]),
        .sload(sload[2]), .sclr_n(sclr_n[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {sclr_n, sclk, sdata, sload, frame_done} of the selected instance
    function automatic logic [4:0] ovec();
        return {sclr_n[sel], sclk[sel], sdata[sel], sload[sel], fd[sel]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ready(input string tag, input logic exp);
        check(tag, {7'b0, rdy[sel]}, {7'b0, exp});
    endtask

    // Checks frame cycles c0..c1 (fc values); pat[k] is the sdata value of slot k.
    // Optionally offers acc_d at cycle acc_c and expects it to be taken.
    task automatic check_frame(input string tag, input logic [7:0] pat, input int c0, input int c1,
                               input int acc_c, input logic [7:0] acc_d);
        logic [4:0] exp;
        logic [2:0] s;
        for (int c = c0; c <= c1; c++) begin
            s = 3'(c / 4);
            if (c < 32) begin
                exp = {1'b1, ((c % 4) >= 2), pat[s], 1'b0, 1'b0};
            end else begin
                exp = {1'b1, 1'b0, 1'b0, 1'b1, (c == 35)};
            end
            check(tag, {3'b0, ovec()}, {3'b0, exp});
            if (acc_c >= 0 && c == acc_c) begin
                display_bits = acc_d;
                update_valid = 1'b1;
            end
            if (acc_c >= 0 && c == acc_c + 1) begin
                update_valid = 1'b0;
                check_ready({tag, "_held"}, 1'b0);
            end
            tick();
        end
    endtask

    task automatic run_wait(input string tag, input int n, input logic exp_rdy);
        for (int i = 0; i < n; i++) begin
            check(tag, {3'b0, ovec()}, 8'h10);
            check_ready({tag, "_rdy"}, exp_rdy);
            tick();
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; sel = 2'd0;
        rst0 = 1'b0; rst_e = 1'b0; rst_m = 1'b0;
        update_valid = 1'b0; display_bits = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            check("reset_outputs", {3'b0, ovec()}, 8'h00);
            check_ready("reset_ready", 1'b0);
        end

        // Plain refresh of an all-zero frame after reset release
        sel = 2'd0;
        rst0 = 1'b1;
        check("t1_c0", {3'b0, ovec()}, 8'h00);
        check_ready("t1_c0_ready", 1'b0);
        tick();
        check_ready("t1_ready", 1'b1);
        check_frame("t1_frame0", 8'h00, 1, 35, -1, 8'h00);
        run_wait("t1_wait", 28, 1'b1);
        check_frame("t1_frame1", 8'h00, 0, 35, -1, 8'h00);

        // Update during WAIT goes out on the next refresh
        run_wait("t2_wait_a", 4, 1'b1);
        display_bits = 8'hA5; update_valid = 1'b1;
        check_ready("t2_offer", 1'b1);
        tick();
        update_valid = 1'b0;
        run_wait("t2_wait_b", 23, 1'b0);
        check_ready("t2_entry_ready", 1'b1);
        check_frame("t2_frame", 8'hA5, 0, 35, -1, 8'h00);
        run_wait("t2_wait_c", 28, 1'b1);

        // Update in slot 3 leaves the frame in flight alone
        check_frame("t3_inflight", 8'hA5, 0, 35, 12, 8'h0F);
        run_wait("t3_wait", 28, 1'b0);
        check_ready("t3_entry_ready", 1'b1);
        check_frame("t3_next", 8'h0F, 0, 35, -1, 8'h00);

        // Second offer held off until the pending buffer drains
        run_wait("t4_wait_a", 2, 1'b1);
        display_bits = 8'h11; update_valid = 1'b1;
        check_ready("t4_offer1", 1'b1);
        tick();
        display_bits = 8'h22;
        run_wait("t4_wait_b", 25, 1'b0);
        check_ready("t4_entry_ready", 1'b1);
        check_frame("t4_first", 8'h11, 0, 35, 0, 8'h22);
        run_wait("t4_wait_c", 28, 1'b0);
        check_ready("t4_entry2_ready", 1'b1);
        check_frame("t4_second", 8'h22, 0, 35, -1, 8'h00);

        // Accept on the SHIFT-entry cycle feeds the frame directly
        run_wait("sc_wait", 27, 1'b1);
        display_bits = 8'h5A; update_valid = 1'b1;
        check_ready("sc_offer", 1'b1);
        tick();
        update_valid = 1'b0;
        check_ready("sc_ready", 1'b1);
        check_frame("sc_frame", 8'h5A, 0, 33, 4, 8'h77);

        // Reset in the middle of LOAD with a pending frame
        check("t7_mid_load", {3'b0, ovec()}, 8'h12);
        check_ready("t7_pending_full", 1'b0);
        rst0 = 1'b0;
        #1;
        check("t7_async_reset", {3'b0, ovec()}, 8'h00);
        check_ready("t7_reset_ready", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b1;
        check("t7_c0", {3'b0, ovec()}, 8'h00);
        tick();
        check_ready("t7_ready", 1'b1);
        check_frame("t7_frame0", 8'h00, 1, 35, -1, 8'h00);
        run_wait("t7_wait", 28, 1'b1);
        check_frame("t7_frame1", 8'h00, 0, 35, -1, 8'h00);
        rst0 = 1'b0;

        // Early update restarts the frame from WAIT
        sel = 2'd1;
        rst_e = 1'b1;
        check("t5_c0", {3'b0, ovec()}, 8'h00);
        tick();
        check_ready("t5_ready", 1'b1);
        check_frame("t5_frame0", 8'h00, 1, 35, -1, 8'h00);
        run_wait("t5_wait_a", 5, 1'b1);
        display_bits = 8'h3C; update_valid = 1'b1;
        check_ready("t5_offer", 1'b1);
        tick();
        update_valid = 1'b0;
        check_ready("t5_after_early", 1'b1);
        check_frame("t5_early", 8'h3C, 0, 35, -1, 8'h00);
        run_wait("t5_wait_b", 28, 1'b1);
        check_frame("t5_refresh", 8'h3C, 0, 35, -1, 8'h00);
        rst_e = 1'b0;

        // MSB-first: 0x80 appears only in slot 0
        sel = 2'd2;
        rst_m = 1'b1;
        check("t6_c0", {3'b0, ovec()}, 8'h00);
        tick();
        check_ready("t6_ready", 1'b1);
        check_frame("t6_frame0", 8'h00, 1, 35, -1, 8'h00);
        run_wait("t6_wait_a", 2, 1'b1);
        display_bits = 8'h80; update_valid = 1'b1;
        check_ready("t6_offer", 1'b1);
        tick();
        update_valid = 1'b0;
        run_wait("t6_wait_b", 25, 1'b0);
        check_ready("t6_entry_ready", 1'b1);
        check_frame("t6_frame", 8'h01, 0, 35, -1, 8'h00);
        rst_m = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
